// File: rtl/nn_f2_maxpool_stream.sv
// 2x2/stride-2 max-pool of one captured conv frame (four 8x8 maps of DW-bit values),
// streamed out as 64 pooled beats over valid/ready with map/row/col tags and frame framing.
module nn_f2_maxpool_stream #(
  parameter int DW   = 2,
  parameter int FM   = 8,
  parameter int NMAP = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [NMAP/2*FM*FM*DW-1:0] in_a,
  input  logic [NMAP/2*FM*FM*DW-1:0] in_b,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DW-1:0]              out_data,
  output logic [1:0]                 out_map,
  output logic [1:0]                 out_row,
  output logic [1:0]                 out_col,
  output logic                       out_last,
  output logic                       frame_done
);

  localparam int BW = NMAP/2*FM*FM*DW;
  localparam int MW = FM*FM*DW;
  localparam int PW = FM/2;

  typedef enum logic [1:0] {IDLE, LOAD, STREAM} state_t;

  state_t          state_r, state_s;
  logic [2*BW-1:0] fbuf_r;
  logic [1:0]      map_nx_s, row_nx_s, col_nx_s;
  logic            last_nx_s;
  logic            xfer_s;

  // Unsigned max over the 2x2 window (r,c) of map m; map m owns slice [m*MW +: MW].
  function automatic logic [DW-1:0] pool_max(input logic [2*BW-1:0] fb,
                                             input logic [1:0] m,
                                             input logic [1:0] r,
                                             input logic [1:0] c);
    int base;
    int rr;
    int cc;
    logic [DW-1:0] e0, e1, e2, e3, mx;
    base = int'(m) * MW;
    rr   = 2 * int'(r);
    cc   = 2 * int'(c);
    e0 = fb[base + DW*(rr*FM + cc)       +: DW];
    e1 = fb[base + DW*(rr*FM + cc + 1)   +: DW];
    e2 = fb[base + DW*((rr+1)*FM + cc)   +: DW];
    e3 = fb[base + DW*((rr+1)*FM + cc+1) +: DW];
    mx = e0;
    if (e1 > mx) mx = e1;
    if (e2 > mx) mx = e2;
    if (e3 > mx) mx = e3;
    return mx;
  endfunction

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    xfer_s  = out_valid & out_ready;
    case (state_r)
      IDLE: begin
        if (in_valid && in_ready) state_s = LOAD;
        else                      state_s = IDLE;
      end
      LOAD:   state_s = STREAM;
      STREAM: begin
        if (xfer_s && out_last) state_s = IDLE;
        else                    state_s = STREAM;
      end
      default: state_s = IDLE;
    endcase
  end

  // Beat order: col fastest, then row, then map.
  always_comb begin
    map_nx_s = out_map;
    row_nx_s = out_row;
    col_nx_s = out_col + 2'd1;
    if (out_col == 2'(PW-1)) begin
      col_nx_s = 2'd0;
      if (out_row == 2'(PW-1)) begin
        row_nx_s = 2'd0;
        map_nx_s = out_map + 2'd1;
      end else begin
        row_nx_s = out_row + 2'd1;
      end
    end else begin
      row_nx_s = out_row;
    end
    last_nx_s = (map_nx_s == 2'(NMAP-1)) && (row_nx_s == 2'(PW-1)) && (col_nx_s == 2'(PW-1));
  end

  // State, frame buffer and registered output beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      in_ready   <= 1'b0;
      fbuf_r     <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_map    <= 2'd0;
      out_row    <= 2'd0;
      out_col    <= 2'd0;
      out_last   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state_r    <= state_s;
      in_ready   <= (state_s == IDLE);
      frame_done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (in_valid && in_ready) fbuf_r <= {in_b, in_a};
        end
        LOAD: begin
          out_map   <= 2'd0;
          out_row   <= 2'd0;
          out_col   <= 2'd0;
          out_data  <= pool_max(fbuf_r, 2'd0, 2'd0, 2'd0);
          out_last  <= 1'b0;
          out_valid <= 1'b1;
        end
        STREAM: begin
          if (xfer_s) begin
            if (out_last) begin
              out_valid  <= 1'b0;
              out_last   <= 1'b0;
              frame_done <= 1'b1;
            end else begin
              out_map  <= map_nx_s;
              out_row  <= row_nx_s;
              out_col  <= col_nx_s;
              out_data <= pool_max(fbuf_r, map_nx_s, row_nx_s, col_nx_s);
              out_last <= last_nx_s;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
